// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core memory arbiter: FSM states, pending-mask
// bit positions and helpers for priority selection and watchdog sizing.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } arb_state_t;

    // Pending-mask bit positions; a lower index means a higher priority.
    localparam int P_WR    = 0;
    localparam int P_DR    = 1;
    localparam int P_IR    = 2;
    localparam int NUM_REQ = 3;

    localparam int TIMER_W_DEFAULT = 8;

    typedef logic [NUM_REQ-1:0] req_mask_t;

    // Isolates the lowest set bit, i.e. the highest-priority pending request.
    function automatic req_mask_t pick_highest(input req_mask_t m);
        return m & (~m + req_mask_t'(1));
    endfunction

    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > TIMER_W_DEFAULT) ? w : TIMER_W_DEFAULT;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog: counts ISSUE cycles without an acknowledge and flags expiry
// in the cycle the count would reach TIMEOUT. TIMEOUT = 0 disables it.
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLEAR,
    input  logic RUN,
    output logic EXPIRE
);

    localparam int            CW   = timer_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (CLEAR) begin
            count <= '0;
        end else if (RUN) begin
            count <= count + CW'(1);
        end
    end

    // Expiry fires during the TIMEOUT-th request cycle so the abort lands
    // exactly TIMEOUT cycles after issue.
    assign EXPIRE = (TIMEOUT != 0) && RUN && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-read, data-read and data-write requests onto one
// memory bus by fixed priority, holding the core with MEM_WAIT meanwhile.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_ROADDR,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA,
    output logic        ARB_TIMEOUT
);

    arb_state_t  state, state_nxt;
    req_mask_t   req_mask, pending, batch, cur_sel, pending_left;
    req_mask_t   src_mask, launch_sel;
    logic        any_req, launch, xfer_done, expire, timed_out;
    logic [31:0] ir_addr_q, dr_addr_q, wr_addr_q, wr_data_q;
    logic [31:0] ir_addr_src, dr_addr_src, wr_addr_src, wr_data_src;
    logic [31:0] bus_addr_nxt;

    assign req_mask[P_WR] = DATA_WREN;
    assign req_mask[P_DR] = DATA_RDEN;
    assign req_mask[P_IR] = INST_RDEN;
    assign any_req        = |req_mask;

    assign cur_sel      = pick_highest(pending);
    assign pending_left = pending & ~cur_sel;
    assign xfer_done    = (state == S_ISSUE) && (BUS_ACK || expire);
    assign timed_out    = expire;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .CLEAR  (launch),
        .RUN    ((state == S_ISSUE) && !BUS_ACK),
        .EXPIRE (expire)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        src_mask  = '0;
        launch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ISSUE;
                    src_mask  = req_mask;
                    launch    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (xfer_done) begin
                    if (|pending_left) begin
                        src_mask = pending_left;
                        launch   = 1'b1;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign launch_sel = pick_highest(src_mask);

    // The first transfer of a batch issues straight from the request ports;
    // later ones use the copies latched when the batch was accepted.
    always_comb begin
        if (state == S_IDLE) begin
            ir_addr_src = INST_RIADDR;
            dr_addr_src = DATA_RIADDR;
            wr_addr_src = DATA_WADDR;
            wr_data_src = DATA_WDATA;
        end else begin
            ir_addr_src = ir_addr_q;
            dr_addr_src = dr_addr_q;
            wr_addr_src = wr_addr_q;
            wr_data_src = wr_data_q;
        end
        bus_addr_nxt = ir_addr_src;
        if (launch_sel[P_WR]) begin
            bus_addr_nxt = wr_addr_src;
        end else if (launch_sel[P_DR]) begin
            bus_addr_nxt = dr_addr_src;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pending   <= '0;
            batch     <= '0;
            ir_addr_q <= '0;
            dr_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && any_req) begin
                pending   <= req_mask;
                batch     <= req_mask;
                ir_addr_q <= INST_RIADDR;
                dr_addr_q <= DATA_RIADDR;
                wr_addr_q <= DATA_WADDR;
                wr_data_q <= DATA_WDATA;
            end else if (xfer_done) begin
                pending <= pending_left;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUS_REQ   <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_ADDR  <= '0;
            BUS_WDATA <= '0;
        end else if (launch) begin
            BUS_REQ  <= 1'b1;
            BUS_WE   <= launch_sel[P_WR];
            BUS_ADDR <= bus_addr_nxt;
            if (launch_sel[P_WR]) begin
                BUS_WDATA <= wr_data_src;
            end
        end else if (xfer_done) begin
            BUS_REQ <= 1'b0;
            BUS_WE  <= 1'b0;
        end
    end

    // Result registers hold their value between batches; an aborted read
    // returns zero rather than whatever happened to be on BUS_RDATA.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            INST_ROADDR <= '0;
            INST_RDATA  <= '0;
            DATA_ROADDR <= '0;
            DATA_RDATA  <= '0;
            ARB_TIMEOUT <= 1'b0;
        end else begin
            if (xfer_done && cur_sel[P_IR]) begin
                INST_ROADDR <= ir_addr_q;
                INST_RDATA  <= BUS_ACK ? BUS_RDATA : '0;
            end
            if (xfer_done && cur_sel[P_DR]) begin
                DATA_ROADDR <= dr_addr_q;
                DATA_RDATA  <= BUS_ACK ? BUS_RDATA : '0;
            end
            if (timed_out) begin
                ARB_TIMEOUT <= 1'b1;
            end
        end
    end

    assign INST_RVALID = (state == S_DONE) && batch[P_IR];
    assign DATA_RVALID = (state == S_DONE) && batch[P_DR];
    assign MEM_WAIT    = ((state == S_IDLE) && any_req) || (state == S_ISSUE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-timeout instance for the main
// scenarios and a TIMEOUT = 4 instance for the watchdog scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;

    // Main instance (TIMEOUT = 255)
    logic        inst_rden = 1'b0, data_rden = 1'b0, data_wren = 1'b0;
    logic [31:0] inst_riaddr = '0, data_riaddr = '0, data_waddr = '0, data_wdata = '0;
    logic        inst_rvalid, data_rvalid, mem_wait, bus_req, bus_we, arb_timeout;
    logic [31:0] inst_roaddr, inst_rdata, data_roaddr, data_rdata, bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    // Watchdog instance (TIMEOUT = 4)
    logic        t_inst_rden = 1'b0, t_data_rden = 1'b0, t_data_wren = 1'b0;
    logic [31:0] t_inst_riaddr = '0, t_data_riaddr = '0, t_data_waddr = '0, t_data_wdata = '0;
    logic        t_inst_rvalid, t_data_rvalid, t_mem_wait, t_bus_req, t_bus_we, t_arb_timeout;
    logic [31:0] t_inst_roaddr, t_inst_rdata, t_data_roaddr, t_data_rdata, t_bus_addr, t_bus_wdata;
    logic        t_bus_ack = 1'b0;
    logic [31:0] t_bus_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .CLK (clk), .RST (rst),
        .INST_RDEN (inst_rden), .INST_RIADDR (inst_riaddr), .INST_RVALID (inst_rvalid),
        .INST_ROADDR (inst_roaddr), .INST_RDATA (inst_rdata),
        .DATA_RDEN (data_rden), .DATA_RIADDR (data_riaddr), .DATA_RVALID (data_rvalid),
        .DATA_ROADDR (data_roaddr), .DATA_RDATA (data_rdata),
        .DATA_WREN (data_wren), .DATA_WADDR (data_waddr), .DATA_WDATA (data_wdata),
        .MEM_WAIT (mem_wait), .BUS_REQ (bus_req), .BUS_WE (bus_we),
        .BUS_ADDR (bus_addr), .BUS_WDATA (bus_wdata),
        .BUS_ACK (bus_ack), .BUS_RDATA (bus_rdata), .ARB_TIMEOUT (arb_timeout)
    );

    mem_arbiter #(.TIMEOUT (4)) dut_to (
        .CLK (clk), .RST (rst),
        .INST_RDEN (t_inst_rden), .INST_RIADDR (t_inst_riaddr), .INST_RVALID (t_inst_rvalid),
        .INST_ROADDR (t_inst_roaddr), .INST_RDATA (t_inst_rdata),
        .DATA_RDEN (t_data_rden), .DATA_RIADDR (t_data_riaddr), .DATA_RVALID (t_data_rvalid),
        .DATA_ROADDR (t_data_roaddr), .DATA_RDATA (t_data_rdata),
        .DATA_WREN (t_data_wren), .DATA_WADDR (t_data_waddr), .DATA_WDATA (t_data_wdata),
        .MEM_WAIT (t_mem_wait), .BUS_REQ (t_bus_req), .BUS_WE (t_bus_we),
        .BUS_ADDR (t_bus_addr), .BUS_WDATA (t_bus_wdata),
        .BUS_ACK (t_bus_ack), .BUS_RDATA (t_bus_rdata), .ARB_TIMEOUT (t_arb_timeout)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, inst_rvalid, data_rvalid, arb_timeout,
             inst_roaddr, inst_rdata, data_roaddr, data_rdata, mem_wait} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h irv=%b drv=%b to=%b wait=%b exp all zero",
                     bus_req, bus_we, bus_addr, bus_wdata, inst_rvalid, data_rvalid, arb_timeout, mem_wait);
        end
        checks++;
        if ({t_bus_req, t_arb_timeout, t_mem_wait, t_data_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_to got req=%b to=%b wait=%b rdata=%h exp all zero",
                     t_bus_req, t_arb_timeout, t_mem_wait, t_data_rdata);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        inst_rden = 1'b1; inst_riaddr = 32'h100;
        @(negedge clk);
        checks++;
        if ({mem_wait, bus_req} !== 2'b10) begin
            failures++;
            $display("FAIL single_c0 wait,req got=%b exp=10", {mem_wait, bus_req});
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, mem_wait, inst_rvalid} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_c1 req=%b we=%b addr=%h wait=%b irv=%b exp 1 0 00000100 1 0",
                     bus_req, bus_we, bus_addr, mem_wait, inst_rvalid);
        end
        step();
        bus_ack = 1'b0; inst_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_rvalid, data_rvalid, inst_roaddr, inst_rdata, mem_wait, bus_req} !==
            {1'b1, 1'b0, 32'h100, 32'h13, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_c2 irv=%b drv=%b roaddr=%h rdata=%h wait=%b req=%b exp 1 0 00000100 00000013 0 0",
                     inst_rvalid, data_rvalid, inst_roaddr, inst_rdata, mem_wait, bus_req);
        end
        step();
        @(negedge clk);
        checks++;
        if ({inst_rvalid, inst_rdata, mem_wait, bus_req} !== {1'b0, 32'h13, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_c3 irv=%b rdata=%h wait=%b req=%b exp 0 00000013 0 0",
                     inst_rvalid, inst_rdata, mem_wait, bus_req);
        end
        step();
    endtask

    task automatic test_all_three();
        data_wren = 1'b1; data_waddr = 32'h200; data_wdata = 32'hDEAD_BEEF;
        data_rden = 1'b1; data_riaddr = 32'h300;
        inst_rden = 1'b1; inst_riaddr = 32'h104;
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_0001;
        @(negedge clk);
        checks++;
        if ({mem_wait, bus_req} !== 2'b10) begin
            failures++;
            $display("FAIL all3_c0 wait,req got=%b exp=10 (ack outside ISSUE)", {mem_wait, bus_req});
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, mem_wait} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1}) begin
            failures++;
            $display("FAIL all3_write req=%b we=%b addr=%h wdata=%h wait=%b exp 1 1 00000200 deadbeef 1",
                     bus_req, bus_we, bus_addr, bus_wdata, mem_wait);
        end
        step();
        bus_rdata = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, mem_wait, data_rvalid} !== {1'b1, 1'b0, 32'h300, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL all3_dread req=%b we=%b addr=%h wait=%b drv=%b exp 1 0 00000300 1 0",
                     bus_req, bus_we, bus_addr, mem_wait, data_rvalid);
        end
        step();
        bus_rdata = 32'h3333_4444;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_we, bus_addr, mem_wait, inst_rvalid} !== {1'b1, 1'b0, 32'h104, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL all3_iread req=%b we=%b addr=%h wait=%b irv=%b exp 1 0 00000104 1 0",
                     bus_req, bus_we, bus_addr, mem_wait, inst_rvalid);
        end
        step();
        bus_ack = 1'b0; data_wren = 1'b0; data_rden = 1'b0; inst_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_rvalid, data_rvalid, mem_wait, bus_req} !== 4'b1100) begin
            failures++;
            $display("FAIL all3_done_flags got=%b exp=1100", {inst_rvalid, data_rvalid, mem_wait, bus_req});
        end
        checks++;
        if ({data_roaddr, data_rdata, inst_roaddr, inst_rdata} !==
            {32'h300, 32'h1111_2222, 32'h104, 32'h3333_4444}) begin
            failures++;
            $display("FAIL all3_done_data droaddr=%h drdata=%h iroaddr=%h irdata=%h exp 00000300 11112222 00000104 33334444",
                     data_roaddr, data_rdata, inst_roaddr, inst_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({inst_rvalid, data_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL all3_after_done rvalids got=%b exp=00", {inst_rvalid, data_rvalid});
        end
        step();
    endtask

    task automatic test_wait_states();
        data_rden = 1'b1; data_riaddr = 32'h340;
        bus_ack = 1'b0; bus_rdata = 32'hBAD0_0000;
        @(negedge clk);
        checks++;
        if (mem_wait !== 1'b1) begin
            failures++;
            $display("FAIL wait_c0 mem_wait got=%b exp=1", mem_wait);
        end
        step();
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                bus_ack = 1'b1; bus_rdata = 32'h5A5A_0006;
            end
            @(negedge clk);
            checks++;
            if ({bus_req, bus_addr, mem_wait, data_rvalid} !== {1'b1, 32'h340, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL wait_cycle%0d req=%b addr=%h wait=%b drv=%b exp 1 00000340 1 0",
                         i, bus_req, bus_addr, mem_wait, data_rvalid);
            end
            step();
        end
        bus_ack = 1'b0; data_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_rvalid, data_rdata, data_roaddr, mem_wait, bus_req} !==
            {1'b1, 32'h5A5A_0006, 32'h340, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wait_done drv=%b rdata=%h roaddr=%h wait=%b req=%b exp 1 5a5a0006 00000340 0 0",
                     data_rvalid, data_rdata, data_roaddr, mem_wait, bus_req);
        end
        step();
        @(negedge clk);
        checks++;
        if ({data_rvalid, arb_timeout} !== 2'b00) begin
            failures++;
            $display("FAIL wait_after drv,timeout got=%b exp=00", {data_rvalid, arb_timeout});
        end
        step();
    endtask

    task automatic test_watchdog_boundary();
        t_data_rden = 1'b1; t_data_riaddr = 32'h600;
        t_bus_ack = 1'b0; t_bus_rdata = 32'hFFFF_FFFF;
        step();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                t_bus_ack = 1'b1; t_bus_rdata = 32'h0000_1234;
            end
            @(negedge clk);
            checks++;
            if ({t_bus_req, t_bus_addr} !== {1'b1, 32'h600}) begin
                failures++;
                $display("FAIL boundary_cycle%0d req=%b addr=%h exp 1 00000600", i, t_bus_req, t_bus_addr);
            end
            step();
        end
        t_bus_ack = 1'b0; t_data_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_data_rvalid, t_data_rdata, t_arb_timeout} !== {1'b1, 32'h1234, 1'b0}) begin
            failures++;
            $display("FAIL boundary_done drv=%b rdata=%h timeout=%b exp 1 00001234 0",
                     t_data_rvalid, t_data_rdata, t_arb_timeout);
        end
        step();
    endtask

    task automatic test_timeout();
        t_data_rden = 1'b1; t_data_riaddr = 32'h400;
        t_bus_ack = 1'b0; t_bus_rdata = 32'hFFFF_FFFF;
        step();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({t_bus_req, t_mem_wait, t_arb_timeout} !== 3'b110) begin
                failures++;
                $display("FAIL timeout_cycle%0d req,wait,timeout got=%b exp=110",
                         i, {t_bus_req, t_mem_wait, t_arb_timeout});
            end
            step();
        end
        t_data_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_data_rvalid, t_data_rdata, t_data_roaddr, t_arb_timeout, t_bus_req, t_mem_wait} !==
            {1'b1, 32'h0, 32'h400, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_abort drv=%b rdata=%h roaddr=%h timeout=%b req=%b wait=%b exp 1 00000000 00000400 1 0 0",
                     t_data_rvalid, t_data_rdata, t_data_roaddr, t_arb_timeout, t_bus_req, t_mem_wait);
        end
        step();
        t_inst_rden = 1'b1; t_inst_riaddr = 32'h500;
        step();
        t_bus_ack = 1'b1; t_bus_rdata = 32'h0000_0077;
        step();
        t_bus_ack = 1'b0; t_inst_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_inst_rvalid, t_inst_rdata, t_arb_timeout} !== {1'b1, 32'h77, 1'b1}) begin
            failures++;
            $display("FAIL timeout_sticky irv=%b rdata=%h timeout=%b exp 1 00000077 1",
                     t_inst_rvalid, t_inst_rdata, t_arb_timeout);
        end
        step();
    endtask

    task automatic test_reset_mid_transfer();
        data_rden = 1'b1; data_riaddr = 32'h700; bus_ack = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_issue req got=%b exp=1", bus_req);
        end
        #2;
        rst = 1'b1; data_rden = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, inst_rvalid, data_rvalid, arb_timeout,
             inst_roaddr, inst_rdata, data_roaddr, data_rdata, mem_wait} !== '0) begin
            failures++;
            $display("FAIL rstmid_async req=%b addr=%h wdata=%h irdata=%h drdata=%h wait=%b exp all zero",
                     bus_req, bus_addr, bus_wdata, inst_rdata, data_rdata, mem_wait);
        end
        step();
        rst = 1'b0;
        step();
        inst_rden = 1'b1; inst_riaddr = 32'h800;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0088;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h800}) begin
            failures++;
            $display("FAIL rstmid_after_issue req=%b addr=%h exp 1 00000800", bus_req, bus_addr);
        end
        step();
        bus_ack = 1'b0; inst_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_rvalid, inst_rdata, inst_roaddr} !== {1'b1, 32'h88, 32'h800}) begin
            failures++;
            $display("FAIL rstmid_after_done irv=%b rdata=%h roaddr=%h exp 1 00000088 00000800",
                     inst_rvalid, inst_rdata, inst_roaddr);
        end
        step();
    endtask

    task automatic test_held_through_done();
        inst_rden = 1'b1; inst_riaddr = 32'h900;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0099;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h900}) begin
            failures++;
            $display("FAIL held_issue req=%b addr=%h exp 1 00000900", bus_req, bus_addr);
        end
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_req, inst_rvalid, inst_rdata, mem_wait} !== {1'b0, 1'b1, 32'h99, 1'b0}) begin
            failures++;
            $display("FAIL held_done req=%b irv=%b rdata=%h wait=%b exp 0 1 00000099 0",
                     bus_req, inst_rvalid, inst_rdata, mem_wait);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus_req, mem_wait, inst_rvalid} !== 3'b010) begin
            failures++;
            $display("FAIL held_resample req,wait,irv got=%b exp=010", {bus_req, mem_wait, inst_rvalid});
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_009A;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h900}) begin
            failures++;
            $display("FAIL held_reissue req=%b addr=%h exp 1 00000900", bus_req, bus_addr);
        end
        step();
        bus_ack = 1'b0; inst_rden = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_rvalid, inst_rdata} !== {1'b1, 32'h9A}) begin
            failures++;
            $display("FAIL held_second_done irv=%b rdata=%h exp 1 0000009a", inst_rvalid, inst_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_three();
        test_wait_states();
        test_watchdog_boundary();
        test_timeout();
        test_reset_mid_transfer();
        test_held_through_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit reached without completing the test sequence");
        $fatal(1);
    end

endmodule
